// File: rtl/pc_fetch_stage_if.sv
// ============================================================================
//  Module   : pc_fetch_stage_if
//  Purpose  : Fetch-stage bus bundle: PC-select loop, imem req/ack, decode valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_fetch_stage_if #(
  parameter int INSTR_W = 32
);
  logic [63:0]        npc;
  logic               redirect;
  logic [63:0]        pc;
  logic [63:0]        pc_plus4;
  logic               imem_req;
  logic [63:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [63:0]        if_pc;
  logic               fetch_fault;

  modport master (
    input  npc, redirect, imem_ack, imem_rdata, if_ready,
    output pc, pc_plus4, imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault
  );

  modport slave (
    output npc, redirect, imem_ack, imem_rdata, if_ready,
    input  pc, pc_plus4, imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_stage.sv
// ============================================================================
//  Module   : pc_fetch_stage
//  Purpose  : PC register, single-outstanding imem fetch, instruction FIFO to decode.
//             Optional misaligned-PC fault enabled by macro ALIGN_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_stage #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          INSTR_W    = 32
) (
  input  logic clk,
  input  logic reset,
  pc_fetch_stage_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_DROP  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [63:0]        drop_addr_q, drop_addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [63:0]        fifo_pc_q    [FIFO_DEPTH];
  logic [INSTR_W-1:0] fifo_instr_q [FIFO_DEPTH];

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic        w_full;
  logic        w_align_ok;

`ifdef ALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign w_align_ok = (pc_q[1:0] == 2'b00);

  // Sticky until a redirect lands on an aligned target.
  always_comb begin
    fault_d = fault_q;
    if (bus.redirect && (bus.npc[1:0] == 2'b00)) begin
      fault_d = 1'b0;
    end else if ((state_q == S_FETCH) && !w_align_ok) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign bus.fetch_fault = fault_q || ((state_q == S_FETCH) && !w_align_ok);
`else
  assign w_align_ok      = 1'b1;
  assign bus.fetch_fault = 1'b0;
`endif

  assign w_full = (count_q == C_DEPTH);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    w_req       = 1'b0;
    w_addr      = pc_q;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    case (state_q)
      S_FETCH: begin
        w_req = !w_full && w_align_ok;
        if (bus.redirect) begin
          pc_d    = bus.npc;
          w_flush = 1'b1;
          // The unanswered request cannot be withdrawn; park it and discard its data.
          if (w_req && !bus.imem_ack) begin
            drop_addr_d = pc_q;
            state_d     = S_DROP;
          end
        end else if (w_req && bus.imem_ack) begin
          w_push = 1'b1;
          pc_d   = bus.npc;
        end
      end
      S_DROP: begin
        w_req  = 1'b1;
        w_addr = drop_addr_q;
        if (bus.redirect) begin
          pc_d    = bus.npc;
          w_flush = 1'b1;
        end
        if (bus.imem_ack) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign w_pop = (count_q != '0) && bus.if_ready && !w_flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_q + 64'd4;
  assign bus.imem_req  = w_req && !reset;
  assign bus.imem_addr = w_addr;
  assign bus.if_valid  = (count_q != '0);
  assign bus.if_instr  = fifo_instr_q[rd_ptr_q];
  assign bus.if_pc     = fifo_pc_q[rd_ptr_q];

endmodule

`default_nettype wire
